// File: rtl/regfile_pkg.sv
// Shared constants and write-source priority for the regfile_sb register file.
package regfile_pkg;

    localparam int unsigned RF_W   = 8;
    localparam int unsigned RF_D   = 4;
    localparam int unsigned RF_NR  = 2;
    localparam int unsigned RF_ACC = 2**RF_D - 1;
    localparam int unsigned RF_LDR = 11;
    localparam int unsigned RF_STR = 12;

    typedef enum logic [1:0] {
        WSRC_NONE,
        WSRC_A,
        WSRC_ACC,
        WSRC_LD
    } wsrc_e;

    // Load return beats accumulate, which beats port A.
    function automatic wsrc_e wsrc_pick(input logic ld_hit,
                                        input logic acc_hit,
                                        input logic a_hit);
        if (ld_hit)
            return WSRC_LD;
        else if (acc_hit)
            return WSRC_ACC;
        else if (a_hit)
            return WSRC_A;
        else
            return WSRC_NONE;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register load-in-flight busy bits, sticky issue error and per-port busy lookup.
// With REGFILE_SB_BYPASS_EN a same-cycle load return hides the busy bit of its port.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned D  = RF_D,
    parameter int unsigned NR = RF_NR
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            LdIssue,
    input  logic [D-1:0]    LdIssueAddr,
    input  logic            LdValid,
    input  logic [D-1:0]    LdAddr,
    input  logic [NR*D-1:0] RaddrIn,
    output logic [NR-1:0]   RdBusy,
    output logic            IssueErr
);

    localparam int unsigned NREG = 2**D;

    logic [NREG-1:0] busy;
    logic [D-1:0]    rd_a;

    // The issue is applied after the return so a same-address issue keeps busy set.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy     <= '0;
            IssueErr <= 1'b0;
        end else begin
            if (LdValid)
                busy[LdAddr] <= 1'b0;
            if (LdIssue) begin
                busy[LdIssueAddr] <= 1'b1;
                if (busy[LdIssueAddr])
                    IssueErr <= 1'b1;
            end
        end
    end

    always_comb begin
        RdBusy = '0;
        rd_a   = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            rd_a      = RaddrIn[i*D +: D];
            RdBusy[i] = busy[rd_a];
`ifdef REGFILE_SB_BYPASS_EN
            if (LdValid && (LdAddr == rd_a) && !(LdIssue && (LdIssueAddr == rd_a)))
                RdBusy[i] = 1'b0;
`endif
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with NR read ports, ALU and load-return write ports, in-place accumulate
// and a load busy scoreboard. Define REGFILE_SB_BYPASS_EN for same-cycle read forwarding.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned W   = RF_W,
    parameter int unsigned D   = RF_D,
    parameter int unsigned NR  = RF_NR,
    parameter int unsigned ACC = 2**D - 1,
    parameter int unsigned LDR = RF_LDR,
    parameter int unsigned STR = RF_STR
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [NR*D-1:0] RaddrIn,
    output logic [NR*W-1:0] DataOut,
    output logic [NR-1:0]   RdBusy,
    output logic            Stall,
    input  logic            WrEnA,
    input  logic [D-1:0]    WaddrA,
    input  logic [W-1:0]    DataA,
    input  logic            AccAddEn,
    input  logic            LdIssue,
    input  logic [D-1:0]    LdIssueAddr,
    input  logic            LdValid,
    input  logic [D-1:0]    LdAddr,
    input  logic [W-1:0]    LdData,
    output logic [W-1:0]    Accumulator,
    output logic            Carry,
    output logic [W-1:0]    LdRegOut,
    output logic [W-1:0]    StRegOut,
    output logic            IssueErr
);

    localparam int unsigned  NREG  = 2**D;
    localparam logic [D-1:0] ACC_A = D'(ACC);
    localparam logic [D-1:0] LDR_A = D'(LDR);
    localparam logic [D-1:0] STR_A = D'(STR);

    logic [W-1:0] regs  [NREG];
    logic [W-1:0] wnext [NREG];
    wsrc_e        wsrc  [NREG];
    logic [W:0]   acc_sum;
    logic [D-1:0] raddr;

    assign acc_sum = {1'b0, regs[ACC_A]} + {1'b0, DataA};

    // Next value of every register; shared by the write path and the forwarding path.
    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            wsrc[r] = wsrc_pick(LdValid && (LdAddr == D'(r)),
                                AccAddEn && (ACC_A == D'(r)),
                                WrEnA && !AccAddEn && (WaddrA == D'(r)));
            case (wsrc[r])
                WSRC_LD:  wnext[r] = LdData;
                WSRC_ACC: wnext[r] = acc_sum[W-1:0];
                WSRC_A:   wnext[r] = DataA;
                default:  wnext[r] = regs[r];
            endcase
        end
    end

    // Carry follows only an accumulate that actually lands in the accumulator.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned r = 0; r < NREG; r++)
                regs[r] <= '0;
            Carry <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++)
                regs[r] <= wnext[r];
            if (wsrc[ACC_A] == WSRC_ACC)
                Carry <= acc_sum[W];
        end
    end

    always_comb begin
        DataOut = '0;
        raddr   = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            raddr = RaddrIn[i*D +: D];
`ifdef REGFILE_SB_BYPASS_EN
            DataOut[i*W +: W] = wnext[raddr];
`else
            DataOut[i*W +: W] = regs[raddr];
`endif
        end
    end

    reg_scoreboard #(
        .D  (D),
        .NR (NR)
    ) u_scoreboard (
        .Clk         (Clk),
        .Reset       (Reset),
        .LdIssue     (LdIssue),
        .LdIssueAddr (LdIssueAddr),
        .LdValid     (LdValid),
        .LdAddr      (LdAddr),
        .RaddrIn     (RaddrIn),
        .RdBusy      (RdBusy),
        .IssueErr    (IssueErr)
    );

    assign Stall       = |RdBusy;
    assign Accumulator = regs[ACC_A];
    assign LdRegOut    = regs[LDR_A];
    assign StRegOut    = regs[STR_A];

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: expectations queued at drive time, popped when sampled.
// Honours REGFILE_SB_BYPASS_EN in its reference model.
module tb_regfile_sb;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] RaddrIn;
    logic [15:0] DataOut;
    logic [1:0] RdBusy;
    logic       Stall;
    logic       WrEnA;
    logic [3:0] WaddrA;
    logic [7:0] DataA;
    logic       AccAddEn;
    logic       LdIssue;
    logic [3:0] LdIssueAddr;
    logic       LdValid;
    logic [3:0] LdAddr;
    logic [7:0] LdData;
    logic [7:0] Accumulator;
    logic       Carry;
    logic [7:0] LdRegOut;
    logic [7:0] StRegOut;
    logic       IssueErr;

    int n_checks = 0;
    int n_fail   = 0;

    int          sel_q [$];
    logic [31:0] exp_q [$];
    string       tag_q [$];

    logic [7:0]  m_r [16];
    logic [15:0] m_busy;
    logic        m_carry;
    logic        m_err;

    always #5 Clk = ~Clk;

    regfile_sb #(
        .W   (8),
        .D   (4),
        .NR  (2),
        .ACC (15),
        .LDR (11),
        .STR (12)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .RaddrIn     (RaddrIn),
        .DataOut     (DataOut),
        .RdBusy      (RdBusy),
        .Stall       (Stall),
        .WrEnA       (WrEnA),
        .WaddrA      (WaddrA),
        .DataA       (DataA),
        .AccAddEn    (AccAddEn),
        .LdIssue     (LdIssue),
        .LdIssueAddr (LdIssueAddr),
        .LdValid     (LdValid),
        .LdAddr      (LdAddr),
        .LdData      (LdData),
        .Accumulator (Accumulator),
        .Carry       (Carry),
        .LdRegOut    (LdRegOut),
        .StRegOut    (StRegOut),
        .IssueErr    (IssueErr)
    );

    // Reference model: later statements override earlier ones (port A < accumulate < load).
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 16; i++) m_r[i] = 8'h00;
            m_busy  = '0;
            m_carry = 1'b0;
            m_err   = 1'b0;
        end else begin : model_upd
            logic [8:0] s;
            logic       pb;
            s  = {1'b0, m_r[15]} + {1'b0, DataA};
            pb = m_busy[LdIssueAddr];
            if (WrEnA && !AccAddEn) m_r[WaddrA] = DataA;
            if (AccAddEn) begin
                m_r[15] = s[7:0];
                if (!(LdValid && LdAddr == 4'd15)) m_carry = s[8];
            end
            if (LdValid) begin
                m_r[LdAddr]    = LdData;
                m_busy[LdAddr] = 1'b0;
            end
            if (LdIssue) begin
                if (pb) m_err = 1'b1;
                m_busy[LdIssueAddr] = 1'b1;
            end
        end
    end

    function automatic logic [7:0] pred_rd(input logic [3:0] a);
        logic [7:0] v;
        v = m_r[a];
`ifdef REGFILE_SB_BYPASS_EN
        if (WrEnA && !AccAddEn && WaddrA == a) v = DataA;
        if (AccAddEn && a == 4'd15) v = m_r[15] + DataA;
        if (LdValid && LdAddr == a) v = LdData;
`endif
        return v;
    endfunction

    function automatic logic pred_busy(input logic [3:0] a);
        logic b;
        b = m_busy[a];
`ifdef REGFILE_SB_BYPASS_EN
        if (LdValid && LdAddr == a && !(LdIssue && LdIssueAddr == a)) b = 1'b0;
`endif
        return b;
    endfunction

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0: return {24'h0, DataOut[7:0]};
            1: return {24'h0, DataOut[15:8]};
            2: return {30'h0, RdBusy};
            3: return {31'h0, Stall};
            4: return {24'h0, Accumulator};
            5: return {31'h0, Carry};
            6: return {31'h0, IssueErr};
            7: return {24'h0, LdRegOut};
            default: return {24'h0, StRegOut};
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push(input int sel, input logic [31:0] val, input string tag);
        sel_q.push_back(sel);
        exp_q.push_back(val);
        tag_q.push_back(tag);
    endtask

    task automatic drain();
        while (sel_q.size() > 0) begin
            int          s;
            logic [31:0] e;
            string       t;
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_eq(t, observe(s), e);
        end
    endtask

    task automatic expect_model();
        logic [3:0] a0, a1;
        logic       b0, b1;
        a0 = RaddrIn[3:0];
        a1 = RaddrIn[7:4];
        b0 = pred_busy(a0);
        b1 = pred_busy(a1);
        push(0, {24'h0, pred_rd(a0)}, "m_rd0");
        push(1, {24'h0, pred_rd(a1)}, "m_rd1");
        push(2, {30'h0, b1, b0}, "m_rdbusy");
        push(3, {31'h0, b0 | b1}, "m_stall");
        push(4, {24'h0, m_r[15]}, "m_acc");
        push(5, {31'h0, m_carry}, "m_carry");
        push(6, {31'h0, m_err}, "m_issueerr");
        push(7, {24'h0, m_r[11]}, "m_ldreg");
        push(8, {24'h0, m_r[12]}, "m_streg");
    endtask

    task automatic idle();
        WrEnA    = 1'b0;
        AccAddEn = 1'b0;
        LdIssue  = 1'b0;
        LdValid  = 1'b0;
    endtask

    // Check pre-edge outputs for the driven inputs, clock once, then drop the enables.
    task automatic tick();
        #1;
        expect_model();
        drain();
        @(posedge Clk);
        #1;
        idle();
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        RaddrIn = '0; WaddrA = '0; DataA = '0; LdIssueAddr = '0; LdAddr = '0; LdData = '0;
        idle();
        repeat (2) @(posedge Clk);
        @(negedge Clk) Reset = 1'b0;
        @(posedge Clk);
        #1;

        // Asynchronous reset clears data and busy before any edge.
        RaddrIn = {4'd5, 4'd3};
        WrEnA = 1'b1; WaddrA = 4'd3; DataA = 8'h55;
        LdIssue = 1'b1; LdIssueAddr = 4'd3;
        tick();
        push(0, 32'h55, "pre_reset_rd0");
        push(3, 32'h1, "pre_reset_stall");
        drain();
        Reset = 1'b1;
        #1;
        push(0, 32'h0, "reset_rd0");
        push(3, 32'h0, "reset_stall");
        push(6, 32'h0, "reset_issueerr");
        drain();
        expect_model();
        drain();
        @(negedge Clk) Reset = 1'b0;
        @(posedge Clk);
        #1;

        // Port A write, read back on port 1.
        WrEnA = 1'b1; WaddrA = 4'd5; DataA = 8'hA5;
`ifdef REGFILE_SB_BYPASS_EN
        push(1, 32'hA5, "wr_cycle_rd1");
`else
        push(1, 32'h00, "wr_cycle_rd1");
`endif
        tick();
        push(1, 32'hA5, "wr_next_rd1");
        drain();

        // Accumulate with and without carry.
        WrEnA = 1'b1; WaddrA = 4'd15; DataA = 8'hF0;
        tick();
        AccAddEn = 1'b1; DataA = 8'h20;
        tick();
        push(4, 32'h10, "acc_wrap");
        push(5, 32'h1, "acc_carry1");
        drain();
        AccAddEn = 1'b1; DataA = 8'h01;
        tick();
        push(4, 32'h11, "acc_inc");
        push(5, 32'h0, "acc_carry0");
        drain();
        AccAddEn = 1'b1; DataA = 8'hF0;
        tick();
        push(4, 32'h01, "acc_wrap2");
        push(5, 32'h1, "acc_carry2");
        drain();

        // Load return beats accumulate beats port A; losing accumulate keeps Carry.
        WrEnA = 1'b1; WaddrA = 4'd15; DataA = 8'h02; AccAddEn = 1'b1;
        LdValid = 1'b1; LdAddr = 4'd15; LdData = 8'h99;
        tick();
        push(4, 32'h99, "prio_acc");
        push(5, 32'h1, "prio_carry_kept");
        drain();

        // Busy set by issue, cleared by return.
        RaddrIn = {4'd5, 4'd7};
        LdIssue = 1'b1; LdIssueAddr = 4'd7;
        tick();
        push(2, 32'h1, "busy_set");
        push(3, 32'h1, "stall_set");
        drain();
        tick();
        push(2, 32'h1, "busy_hold");
        push(3, 32'h1, "stall_hold");
        drain();
        LdValid = 1'b1; LdAddr = 4'd7; LdData = 8'h3C;
        tick();
        push(2, 32'h0, "busy_clr");
        push(3, 32'h0, "stall_clr");
        push(0, 32'h3C, "ld_data");
        drain();

        // Double issue sets the sticky error; issue+return keeps busy.
        LdIssue = 1'b1; LdIssueAddr = 4'd9;
        tick();
        push(6, 32'h0, "issueerr_first");
        drain();
        LdIssue = 1'b1; LdIssueAddr = 4'd9;
        tick();
        push(6, 32'h1, "issueerr_set");
        drain();
        tick();
        push(6, 32'h1, "issueerr_sticky");
        drain();
        RaddrIn = {4'd5, 4'd9};
        LdIssue = 1'b1; LdIssueAddr = 4'd9;
        LdValid = 1'b1; LdAddr = 4'd9; LdData = 8'h44;
        tick();
        push(2, 32'h1, "issue_ret_busy");
        push(0, 32'h44, "issue_ret_data");
        drain();

        // Mirrored load/store registers.
        WrEnA = 1'b1; WaddrA = 4'd11; DataA = 8'h6B;
        tick();
        WrEnA = 1'b1; WaddrA = 4'd12; DataA = 8'hD2;
        tick();
        push(7, 32'h6B, "ldreg");
        push(8, 32'hD2, "streg");
        drain();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            RaddrIn     = 8'($urandom);
            WrEnA       = ($urandom_range(0, 1) == 1);
            WaddrA      = 4'($urandom);
            DataA       = 8'($urandom);
            AccAddEn    = ($urandom_range(0, 3) == 0);
            LdIssue     = ($urandom_range(0, 3) == 0);
            LdIssueAddr = 4'($urandom);
            LdValid     = ($urandom_range(0, 2) == 0);
            LdAddr      = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            LdData      = 8'($urandom);
            tick();
        end
        expect_model();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
